fetch_controller: RTL and testbench

- Sequences the dual-issue instruction ROM.
- Owns the fetch PC, drives the ROM address each cycle, and captures the two returned words plus per-slot valid bits into a registered fetch bundle.
- Presents the bundle to decode over a valid/ready handshake.
- Handles backend redirects (branch/flush), backpressure, and end-of-program detection. Sits between the ROM and the decode/instruction queue.

---
 rtl/fetch_controller.sv | 136 +++++++++++++
 tb/tb_fetch_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: owns the fetch PC for a dual-issue combinational ROM,
// captures two words plus per-slot valid bits into a registered bundle and
// hands that bundle to decode over a valid/ready handshake. Handles backend
// redirects, decode backpressure and end-of-program detection.
module fetch_controller #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_inst0,
    input  logic [DATA_WIDTH-1:0] rom_inst1,
    input  logic [1:0]            rom_valid,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst0,
    output logic [DATA_WIDTH-1:0] out_inst1,
    output logic [1:0]            out_slot_valid,
    output logic                  fetch_done,
    output logic [31:0]           stall_cycles
);

    typedef enum logic {
        FETCH = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP_ONE = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] STEP_TWO = ADDR_WIDTH'(8);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   redirect_target;
    logic [1:0]              mask;
    logic                    fetching;
    logic                    cap;
    logic                    consume;

    // Slot 1 only counts when slot 0 is also valid; a lone slot-1 valid is
    // treated as an empty fetch (end of program).
    assign mask = {rom_valid[1] & rom_valid[0], rom_valid[0]};

    // The ROM is addressed straight from the PC register so the address
    // never depends on same-cycle handshake or redirect inputs.
    assign rom_addr = pc;

    // Redirect targets are forced to word alignment.
    assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    // A new bundle is taken when fetching, no redirect is pending, the ROM
    // has at least slot 0, and the output register is empty or draining.
    assign cap     = fetching & ~redirect_valid & mask[0] & (~out_valid | out_ready);
    assign consume = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state: redirect always returns to FETCH; an empty ROM slot 0
    // while fetching ends the program.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = FETCH;
        end else if (state == FETCH && !mask[0]) begin
            state_next = DONE;
        end
    end

    // State-decoded outputs.
    always_comb begin
        fetching   = 1'b0;
        fetch_done = 1'b0;
        case (state)
            FETCH:   fetching   = 1'b1;
            DONE:    fetch_done = 1'b1;
            default: ;
        endcase
    end

    // Fetch PC: redirect wins, otherwise advance by the number of slots taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_target;
        end else if (cap) begin
            pc <= pc + (mask[1] ? STEP_TWO : STEP_ONE);
        end
    end

    // Bundle register: flushed by redirect, loaded on capture, emptied when
    // decode takes it and nothing replaces it; held under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_slot_valid <= 2'b00;
            out_pc         <= '0;
            out_inst0      <= '0;
            out_inst1      <= '0;
        end else if (redirect_valid) begin
            out_valid      <= 1'b0;
            out_slot_valid <= 2'b00;
        end else if (cap) begin
            out_valid      <= 1'b1;
            out_slot_valid <= mask;
            out_pc         <= pc;
            out_inst0      <= rom_inst0;
            out_inst1      <= rom_inst1;
        end else if (consume) begin
            out_valid      <= 1'b0;
            out_slot_valid <= 2'b00;
        end
    end

    // Stall counter: cycles a bundle is offered but refused; wraps freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed stimulus with a scoreboard. The stimulus
// thread queues hand-computed bundles; a monitor thread pops and compares
// each bundle as decode accepts it. ROM word at byte address a is A000_0000|a.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst0;
    logic [31:0] rom_inst1;
    logic [1:0]  rom_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst0;
    logic [31:0] out_inst1;
    logic [1:0]  out_slot_valid;
    logic        fetch_done;
    logic [31:0] stall_cycles;

    logic [31:0] rom_words;
    logic [31:0] rom_lim;
    logic        odd_en;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [1:0]  m;
    } bundle_t;

    bundle_t exp_q[$];
    bundle_t mon_b;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr),
        .rom_inst0(rom_inst0), .rom_inst1(rom_inst1), .rom_valid(rom_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_slot_valid(out_slot_valid), .fetch_done(fetch_done),
        .stall_cycles(stall_cycles)
    );

    // Combinational ROM model with an optional odd-mask override at 0x20.
    assign rom_lim = rom_words << 2;
    always_comb begin
        rom_inst0 = 32'hA000_0000 | rom_addr;
        rom_inst1 = 32'hA000_0000 | (rom_addr + 32'd4);
        rom_valid = {(rom_addr + 32'd4) < rom_lim, rom_addr < rom_lim};
        if (odd_en && rom_addr == 32'h20) rom_valid = 2'b10;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [1:0] m);
        bundle_t b;
        b.pc = pc; b.i0 = i0; b.i1 = i1; b.m = m;
        exp_q.push_back(b);
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!fetch_done && n < max) begin
            tick;
            n++;
        end
        chk("done_timeout", 32'(fetch_done), 32'd1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_slot_valid"}, 32'(out_slot_valid), 32'd0);
        chk({tag, "_out_pc"}, out_pc, 32'd0);
        chk({tag, "_inst0"}, out_inst0, 32'd0);
        chk({tag, "_inst1"}, out_inst1, 32'd0);
        chk({tag, "_fetch_done"}, 32'(fetch_done), 32'd0);
        chk({tag, "_stall"}, stall_cycles, 32'd0);
        chk({tag, "_rom_addr"}, rom_addr, 32'd0);
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        out_ready = 1'b1; rom_words = 32'd5; odd_en = 1'b0;

        // Monitor: compare every accepted bundle against the scoreboard.
        fork
            forever begin
                @(negedge clk);
                if (!rst && !redirect_valid && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bundle: got pc %h expected none", out_pc);
                    end else begin
                        mon_b = exp_q.pop_front();
                        chk("bundle_pc", out_pc, mon_b.pc);
                        chk("bundle_mask", 32'(out_slot_valid), 32'(mon_b.m));
                        chk("bundle_inst0", out_inst0, mon_b.i0);
                        if (mon_b.m[1]) chk("bundle_inst1", out_inst1, mon_b.i1);
                    end
                end
            end
        join_none

        tick; tick;
        reset_checks("reset");

        // Streaming: 5 ROM words -> 0/11, 8/11, 0x10/01, then done.
        push(32'h0,  32'hA000_0000, 32'hA000_0004, 2'b11);
        push(32'h8,  32'hA000_0008, 32'hA000_000C, 2'b11);
        push(32'h10, 32'hA000_0010, 32'hA000_0014, 2'b01);
        rst = 1'b0;
        tick; tick; tick; tick;
        chk("stream_done", 32'(fetch_done), 32'd1);
        chk("stream_out_valid", 32'(out_valid), 32'd0);
        chk("stream_rom_addr", rom_addr, 32'h14);

        // Redirect out of DONE, then backpressure with pc=8 pending.
        push(32'h0,  32'hA000_0000, 32'hA000_0004, 2'b11);
        push(32'h8,  32'hA000_0008, 32'hA000_000C, 2'b11);
        push(32'h10, 32'hA000_0010, 32'hA000_0014, 2'b01);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick;
        chk("rdone_fetch_done", 32'(fetch_done), 32'd0);
        chk("rdone_out_valid", 32'(out_valid), 32'd0);
        chk("rdone_rom_addr", rom_addr, 32'h0);
        redirect_valid = 1'b0;
        tick;
        chk("rdone_bundle_valid", 32'(out_valid), 32'd1);
        chk("rdone_bundle_pc", out_pc, 32'h0);
        tick;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("bp_stall", stall_cycles, 32'(k));
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_pc", out_pc, 32'h8);
            chk("bp_inst0", out_inst0, 32'hA000_0008);
            chk("bp_inst1", out_inst1, 32'hA000_000C);
            chk("bp_rom_addr", rom_addr, 32'h10);
            if (k < 3) tick;
        end
        out_ready = 1'b1;
        wait_done(10);
        chk("bp_end_valid", 32'(out_valid), 32'd0);

        // Redirect to 0x7 while pc=0 bundle is held and ready=1: discarded.
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick;
        redirect_valid = 1'b0; out_ready = 1'b0;
        tick;
        chk("mid_held_valid", 32'(out_valid), 32'd1);
        chk("mid_held_pc", out_pc, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h7; out_ready = 1'b1;
        tick;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_slot_valid", 32'(out_slot_valid), 32'd0);
        chk("mid_rom_addr", rom_addr, 32'h4);
        push(32'h4, 32'hA000_0004, 32'hA000_0008, 2'b11);
        push(32'hC, 32'hA000_000C, 32'hA000_0010, 2'b11);
        redirect_valid = 1'b0;
        tick;
        chk("mid_bundle_valid", 32'(out_valid), 32'd1);
        chk("mid_bundle_pc", out_pc, 32'h4);
        wait_done(10);
        chk("mid_stall", stall_cycles, 32'd3);

        // Odd ROM mask 2'b10 at 0x20: treated as end of program.
        rom_words = 32'd16; odd_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick;
        chk("odd_rom_addr", rom_addr, 32'h20);
        chk("odd_not_done", 32'(fetch_done), 32'd0);
        redirect_valid = 1'b0;
        tick;
        chk("odd_done", 32'(fetch_done), 32'd1);
        chk("odd_out_valid", 32'(out_valid), 32'd0);
        tick;
        chk("odd_pc_hold", rom_addr, 32'h20);
        chk("odd_done_hold", 32'(fetch_done), 32'd1);
        odd_en = 1'b0;

        // Reset mid-operation with redirect and a held bundle.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8;
        tick;
        redirect_valid = 1'b0;
        tick; tick;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_pc", out_pc, 32'h8);
        chk("pre_rst_stall", stall_cycles, 32'd4);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
        tick;
        reset_checks("midrst");
        rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        tick;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_inst0", out_inst0, 32'hA000_0000);
        chk("post_rst_rom_addr", rom_addr, 32'h8);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
